// File: rtl/id_ex_if.sv
// id_ex_if: ID-side operands/control, WB write port, and EX-side outputs of the
// ID/EX pipeline register, bundled for the stage and its environment.
interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 6
);
    // ID stage inputs
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rd_addr;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [CTRL_W-1:0] id_ctrl;

    // WB write port (same signals that drive the register file)
    logic              wb_reg_write;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;

    // EX stage outputs
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1_addr;
    logic [4:0]        ex_rs2_addr;
    logic [4:0]        ex_rd_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              load_use_hazard;

    // Pipeline environment: drives ID/WB, observes EX
    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_rd_addr, id_reg_write,
               id_mem_read, id_mem_write, id_ctrl, wb_reg_write, wb_addr, wb_data,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr,
               ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_ctrl, load_use_hazard
    );

    // The ID/EX register itself
    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_rd_addr, id_reg_write,
               id_mem_read, id_mem_write, id_ctrl, wb_reg_write, wb_addr, wb_data,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr,
               ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_ctrl, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB write-through bypass on load,
// operand refresh while stalled, flush-to-bubble, and load-use hazard detection.
// Optional statistics counters are compiled in with `define ID_EX_STATS_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    id_ex_if.slave      bus
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_bubbles
`endif
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [CTRL_W-1:0] ctrl;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t ex_d;

    // The register file returns stale data in its write cycle, so a WB write to a
    // register being read (or held) must be picked up here. x0 never forwards.
    logic wb_hit_id_rs1, wb_hit_id_rs2, wb_hit_ex_rs1, wb_hit_ex_rs2;

    assign wb_hit_id_rs1 = bus.wb_reg_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.id_rs1_addr);
    assign wb_hit_id_rs2 = bus.wb_reg_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.id_rs2_addr);
    assign wb_hit_ex_rs1 = bus.wb_reg_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == ex_q.rs1_addr);
    assign wb_hit_ex_rs2 = bus.wb_reg_write && (bus.wb_addr != 5'd0) && (bus.wb_addr == ex_q.rs2_addr);

    // Next-state selection: flush beats stall beats load.
    always_comb begin
        // NOTE: ex_d takes a full default before any branch, so no path leaves it unassigned and no latch is inferred.
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            if (wb_hit_ex_rs1) ex_d.rs1_data = bus.wb_data;
            if (wb_hit_ex_rs2) ex_d.rs2_data = bus.wb_data;
        end else begin
            ex_d.valid     = bus.id_valid;
            ex_d.pc        = bus.id_pc;
            ex_d.rs1_data  = wb_hit_id_rs1 ? bus.wb_data : bus.id_rs1_data;
            ex_d.rs2_data  = wb_hit_id_rs2 ? bus.wb_data : bus.id_rs2_data;
            ex_d.imm       = bus.id_imm;
            ex_d.rs1_addr  = bus.id_rs1_addr;
            ex_d.rs2_addr  = bus.id_rs2_addr;
            ex_d.rd_addr   = bus.id_rd_addr;
            ex_d.reg_write = bus.id_valid && bus.id_reg_write;
            ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
            ex_d.mem_write = bus.id_valid && bus.id_mem_write;
            ex_d.ctrl      = bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    // Pipeline register; reset clears everything regardless of stall/flush.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rs1_data  = ex_q.rs1_data;
    assign bus.ex_rs2_data  = ex_q.rs2_data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs1_addr  = ex_q.rs1_addr;
    assign bus.ex_rs2_addr  = ex_q.rs2_addr;
    assign bus.ex_rd_addr   = ex_q.rd_addr;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_ctrl      = ex_q.ctrl;

    // A load in EX whose destination feeds the ID instruction; the external
    // hazard unit decides what to do with it, so no stall/flush gating here.
    assign bus.load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
                                 ((bus.id_uses_rs1 && (bus.id_rs1_addr == ex_q.rd_addr)) ||
                                  (bus.id_uses_rs2 && (bus.id_rs2_addr == ex_q.rd_addr)));

`ifdef ID_EX_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        stall_evt;
    logic        bubble_evt;

    assign stall_evt  = stall && !flush;
    assign bubble_evt = flush || (!stall && !bus.id_valid);

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1))   stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (bubble_evt && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
    assign stat_bubbles      = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage. Expected EX contents are
// queued when stimulus is driven and compared one cycle later. Stats checks are
// compiled in with `define ID_EX_STATS_EN.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [5:0]  ctrl;
    } ex_t;

    typedef struct {
        string tag;
        ex_t   val;
    } sb_t;

    logic clk;
    logic rst;
    logic stall;
    logic flush;
    int   tests_run;
    int   tests_failed;
    sb_t  sb_q[$];

`ifdef ID_EX_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_bubbles;
`endif

    id_ex_if #(.XLEN(32), .CTRL_W(6)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
`ifdef ID_EX_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_bubbles      (stat_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic ex_t mk(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic mw, input logic [5:0] ctrl);
        ex_t e;
        e.valid = v;      e.pc = pc;        e.rs1_data = d1;   e.rs2_data = d2;
        e.imm = imm;      e.rs1_addr = a1;  e.rs2_addr = a2;   e.rd_addr = rd;
        e.reg_write = rw; e.mem_read = mr;  e.mem_write = mw;  e.ctrl = ctrl;
        return e;
    endfunction

    function automatic ex_t obs();
        return mk(bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                  bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr, bus.ex_reg_write,
                  bus.ex_mem_read, bus.ex_mem_write, bus.ex_ctrl);
    endfunction

    task automatic check_ex(input string tag, input ex_t got, input ex_t exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_ex(input string tag, input ex_t val);
        sb_t s;
        s.tag = tag;
        s.val = val;
        sb_q.push_back(s);
    endtask

    // One clock edge, then compare against the oldest pending expectation.
    task automatic tick();
        sb_t s;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check_ex(s.tag, obs(), s.val);
        end
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                            input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw, input logic [5:0] ctrl);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_rs1_addr  = a1;
        bus.id_rs1_data  = d1;
        bus.id_rs2_addr  = a2;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_rd_addr   = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_ctrl      = ctrl;
        bus.id_uses_rs1  = 1'b1;
        bus.id_uses_rs2  = 1'b1;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_reg_write = we;
        bus.wb_addr      = a;
        bus.wb_data      = d;
    endtask

    initial begin
        ex_t zero;
        ex_t held;
        zero = '0;
        tests_run    = 0;
        tests_failed = 0;

        // Reset state
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 6'h0);
        wb(1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check_ex("reset_state", obs(), zero);
        check_val("reset_hazard", {31'd0, bus.load_use_hazard}, 32'd0);
        rst = 1'b0;

        // Plain load, one-cycle latency
        drive_id(1'b1, 32'h100, 5'd5, 32'h11, 5'd6, 32'h22, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 6'h15);
        expect_ex("load_basic", mk(1'b1, 32'h100, 32'h11, 32'h22, 32'h44, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 6'h15));
        tick();

        // WB bypass onto rs1
        drive_id(1'b1, 32'h104, 5'd3, 32'hAAAA, 5'd4, 32'h77, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 6'h01);
        wb(1'b1, 5'd3, 32'h5555);
        expect_ex("bypass_rs1", mk(1'b1, 32'h104, 32'h5555, 32'h77, 32'h0, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 6'h01));
        tick();

        // rs1 == rs2 both bypassed
        drive_id(1'b1, 32'h108, 5'd8, 32'h1, 5'd8, 32'h2, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 6'h02);
        wb(1'b1, 5'd8, 32'h1234);
        expect_ex("bypass_both", mk(1'b1, 32'h108, 32'h1234, 32'h1234, 32'h0, 5'd8, 5'd8, 5'd13, 1'b1, 1'b0, 1'b0, 6'h02));
        tick();

        // x0 never bypassed
        drive_id(1'b1, 32'h10C, 5'd0, 32'h0, 5'd2, 32'h33, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 6'h03);
        wb(1'b1, 5'd0, 32'h9999);
        expect_ex("no_bypass_x0", mk(1'b1, 32'h10C, 32'h0, 32'h33, 32'h0, 5'd0, 5'd2, 5'd14, 1'b1, 1'b0, 1'b0, 6'h03));
        tick();

        // Bubble load: controls forced to 0, data still captured
        drive_id(1'b0, 32'h110, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'h5, 5'd15, 1'b1, 1'b1, 1'b1, 6'h3F);
        wb(1'b0, 5'd0, 32'h0);
        expect_ex("bubble_load", mk(1'b0, 32'h110, 32'hA1, 32'hA2, 32'h5, 5'd1, 5'd2, 5'd15, 1'b0, 1'b0, 1'b0, 6'h00));
        tick();

        // Stall with operand refresh on rs2 in the second stalled cycle
        drive_id(1'b1, 32'h200, 5'd10, 32'h2, 5'd9, 32'h1, 32'h8, 5'd11, 1'b1, 1'b1, 1'b0, 6'h04);
        held = mk(1'b1, 32'h200, 32'h2, 32'h1, 32'h8, 5'd10, 5'd9, 5'd11, 1'b1, 1'b1, 1'b0, 6'h04);
        expect_ex("stall_base", held);
        tick();
        stall = 1'b1;
        drive_id(1'b1, 32'h300, 5'd9, 32'hDEAD, 5'd10, 32'hDEAD, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 6'h07);
        expect_ex("stall_c1", held);
        tick();
        wb(1'b1, 5'd9, 32'hBEEF);
        held.rs2_data = 32'hBEEF;
        expect_ex("stall_c2_refresh", held);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        expect_ex("stall_c3", held);
        tick();

        // Flush beats stall
        flush = 1'b1;
        expect_ex("flush_over_stall", zero);
        tick();
        flush = 1'b0;
        stall = 1'b0;

        // Load-use hazard detection
        drive_id(1'b1, 32'h400, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 6'h05);
        expect_ex("load_in_ex", mk(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 6'h05));
        tick();
        stall = 1'b1;
        bus.id_rs1_addr = 5'd1; bus.id_uses_rs1 = 1'b0;
        bus.id_rs2_addr = 5'd4; bus.id_uses_rs2 = 1'b1;
        #1 check_val("hazard_rs2", {31'd0, bus.load_use_hazard}, 32'd1);
        bus.id_uses_rs2 = 1'b0;
        #1 check_val("hazard_rs2_unused", {31'd0, bus.load_use_hazard}, 32'd0);
        bus.id_rs1_addr = 5'd4; bus.id_uses_rs1 = 1'b1;
        #1 check_val("hazard_rs1", {31'd0, bus.load_use_hazard}, 32'd1);
        stall = 1'b0;
        drive_id(1'b1, 32'h404, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 6'h05);
        expect_ex("load_rd0", mk(1'b1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 6'h05));
        tick();
        bus.id_rs2_addr = 5'd0; bus.id_uses_rs2 = 1'b1;
        bus.id_rs1_addr = 5'd0; bus.id_uses_rs1 = 1'b1;
        #1 check_val("hazard_rd0", {31'd0, bus.load_use_hazard}, 32'd0);

        // Asynchronous reset between edges
        drive_id(1'b1, 32'h500, 5'd3, 32'h31, 5'd4, 32'h41, 32'h9, 5'd6, 1'b1, 1'b0, 1'b1, 6'h2A);
        expect_ex("pre_reset_load", mk(1'b1, 32'h500, 32'h31, 32'h41, 32'h9, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 6'h2A));
        tick();
        #2 rst = 1'b1;
        #1 check_ex("async_reset", obs(), zero);

`ifdef ID_EX_STATS_EN
        check_val("stats_reset_stall", stat_stall_cycles, 32'd0);
        check_val("stats_reset_bubble", stat_bubbles, 32'd0);
`endif

        // Five stalled edges then two flushes, released while stall is already high
        stall = 1'b1;
        bus.id_valid = 1'b1;
        #2 rst = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        stall = 1'b0;
        check_ex("after_flushes", obs(), zero);

`ifdef ID_EX_STATS_EN
        #1;
        check_val("stats_stall_cycles", stat_stall_cycles, 32'd5);
        check_val("stats_bubbles", stat_bubbles, 32'd2);
        rst = 1'b1;
        #1;
        check_val("stats_clear_stall", stat_stall_cycles, 32'd0);
        check_val("stats_clear_bubble", stat_bubbles, 32'd0);
        rst = 1'b0;
`endif

        check_val("scoreboard_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures the two register-file read operands, immediate, PC, destination and control, and presents them to EX one cycle later.
- Write-through bypass of the same-cycle WB write, since the register file reads old data during its write cycle.
- Supports stall and flush; detects load-use hazards; refreshes held operands during stalls.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CTRL_W, 6, width of the opaque EX/MEM/WB control bundle passed through (ALU op, MemtoReg, etc.).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold EX contents
- flush  in  1  insert bubble
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  decoded immediate
- id_rd_addr  in  5  destination index
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- id_ctrl  in  CTRL_W  opaque control bundle
- wb_reg_write  in  1  WB write enable (same signal driven to register file)
- wb_addr  in  5  WB destination
- wb_data  in  XLEN  WB write data
- ex_valid  out  1
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5
- ex_reg_write, ex_mem_read, ex_mem_write  out  1
- ex_ctrl  out  CTRL_W
- load_use_hazard  out  1  combinational stall request to hazard/PC logic

Behaviour:
- Reset (async, rst=1): every ex_* output is 0, including ex_valid. Stats counters are 0. Release takes effect at the next clk edge.
- Latency: 1 cycle. ID values present before edge N appear on ex_* after edge N.
- Priority at each posedge: flush > stall > load.
- Flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl, ex_rd_addr all become 0. Data fields become 0.
- Load (stall=0, flush=0): all fields captured from id_*. ex_valid=id_valid.
  - If id_valid=0, control bits are captured as 0 (bubble).
- WB bypass on load:
  - Captured rs1 = wb_data if wb_reg_write && wb_addr!=0 && wb_addr==id_rs1_addr; else id_rs1_data. Same rule for rs2.
  - x0 is never bypassed.
- Stall (stall=1, flush=0): all fields hold, except for operand refresh.
  - Operand refresh: if wb_reg_write && wb_addr!=0 && wb_addr==ex_rs1_addr, ex_rs1_data <= wb_data. Same for rs2.
  - Ensures producers retiring during a stall are not lost.
- load_use_hazard = ex_valid && ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
  - Purely combinational from current ex_* and id_*.
  - Not gated by stall or flush; the external hazard unit decides.
- Simultaneous rs1==rs2 matching a WB write: both operands get wb_data.
- rst asserted mid-stall or mid-flush clears everything immediately. Stall and flush are ignored while rst=1.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- Defined:
  - Adds output stat_stall_cycles [31:0]: increments on each edge with stall=1 and flush=0.
  - Adds output stat_bubbles [31:0]: increments on each edge that loads a bubble (flush=1, or a load with id_valid=0).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 asynchronously.
- Not defined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset then load: rst pulse; load id_pc=0x100, rs1=5 data 0x11, rs2=6 data 0x22, rd=7, reg_write=1 -> next cycle ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22, ex_rd_addr=7, ex_valid=1.
- WB bypass: id_rs1_addr=3, id_rs1_data=0xAAAA; wb_reg_write=1, wb_addr=3, wb_data=0x5555 -> ex_rs1_data=0x5555. Repeat with wb_addr=0 and id_rs1_addr=0 -> ex_rs1_data=0 (id data 0), no bypass.
- Stall refresh: EX holds ex_rs2_addr=9, ex_rs2_data=0x1; stall=1 for 3 cycles with wb write x9=0xBEEF in cycle 2 -> all fields held, ex_rs2_data becomes 0xBEEF, ex_pc unchanged.
- Flush beats stall: stall=1, flush=1 together with EX valid -> ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd_addr=0.
- Load-use: ex holds mem_read=1, rd=4, valid=1; id_rs2_addr=4, id_uses_rs2=1 -> load_use_hazard=1. Same with id_uses_rs2=0 -> 0. Same with rd=0 -> 0.
- Async reset mid-operation: assert rst between edges while ex_valid=1 -> all ex_* 0 before next edge. With ID_EX_STATS_EN: 5 stall cycles plus 2 flushes -> stat_stall_cycles=5, stat_bubbles=2, then 0 after rst.
